grf_wb_arbiter: RTL and testbench
=================================

Name: grf_wb_arbiter

Overview:
- Producer side of the GRF write port (WE/WA/WD/PC). It merges two write sources onto the single write port.
- Source 1 is the in-order pipeline writeback. It has fixed priority and is never stalled.
- Source 2 is a multi-cycle auxiliary unit (MDU/late-load return). It uses a valid/ready handshake and is buffered in a small FIFO.
- A per-register pending scoreboard is exported so the hazard unit can stall readers of registers with queued writes.

Parameters:
- DEPTH, 4, aux FIFO entries; power of two, 2..16.
- AW, $clog2(DEPTH), FIFO pointer width (derived; not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- pipe_we  in  1  pipeline writeback request this cycle
- pipe_wa  in  5  pipeline destination register
- pipe_wd  in  32  pipeline write data
- pipe_pc  in  32  PC of the writing instruction
- aux_valid  in  1  aux result offered
- aux_wa  in  5  aux destination register
- aux_wd  in  32  aux result data
- aux_pc  in  32  PC of the originating instruction
- aux_ready  out  1  FIFO can accept an entry this cycle
- grf_we  out  1  GRF write enable (registered)
- grf_wa  out  5  GRF write address (registered)
- grf_wd  out  32  GRF write data (registered)
- grf_pc  out  32  PC forwarded to the GRF trace (registered)
- rs_addr  in  5  scoreboard query address 1
- rt_addr  in  5  scoreboard query address 2
- rs_pending  out  1  live FIFO entry targets rs_addr (combinational)
- rt_pending  out  1  live FIFO entry targets rt_addr (combinational)
- pending_cnt  out  AW+1  FIFO occupancy, stale entries included

Behaviour:
- Reset: grf_we=0, grf_wa=0, grf_wd=0, grf_pc=0. FIFO is emptied and all live bits cleared, so pending_cnt=0 and rs/rt_pending=0. Reset overrides any concurrent push, pop or pipe write.
- Writes to register 0 are never emitted and never enqueued:
  - pipe_we with pipe_wa=0 is treated as no request.
  - aux_valid with aux_wa=0 still completes the handshake but is dropped.
- aux_ready = (pending_cnt < DEPTH). It depends only on state, not on aux_valid, and stays low whenever the FIFO is full, even if a pop occurs that same cycle.
- Push: aux_valid && aux_ready && aux_wa!=0 writes {live=1, wa, wd, pc} at the tail.
- Output select, evaluated each cycle and registered at the next edge (latency 1):
  1. Pipe request valid -> emit the pipe write. The FIFO does not pop.
  2. Otherwise, if the FIFO head is live -> emit the head and pop it.
  3. Otherwise, if the FIFO head is stale -> pop it; grf_we=0.
  4. Otherwise -> grf_we=0.
- When grf_we=0, grf_wa/wd/pc hold their previous values.
- Pop of a stale head costs one cycle and performs no write.
- WAW kill: a pipe write to register R clears live on every FIFO entry with wa=R. The pipe instruction is younger than any queued aux result.
  - The kill applies in the same cycle as the emit.
  - An entry pushed in that same cycle with aux_wa=R is not killed; it is younger.
- Simultaneous push and pop: allowed when not full. pending_cnt is unchanged.
- rs_pending = OR over entries (live && wa==rs_addr && rs_addr!=0). rt_pending is the same for rt_addr. The registered output stage is not counted as pending; the GRF commits it on the next edge.
- Pointer wrap: head/tail are AW bits wrapping modulo DEPTH. pending_cnt is AW+1 bits and ranges 0..DEPTH.
- Starvation: a continuous pipe stream may hold the FIFO indefinitely; this is accepted by design.

Optional Feature:
- WB_TRACE_EN defined: on every cycle grf_we is asserted, the block prints "@<pc hex>: $<wa dec> <= <wd hex>". It also prints "KILL $<wa>" for each WAW-killed entry.
- Undefined: no system tasks are compiled in. RTL behaviour is identical either way.

Decomposition:
- Package wb_pkg holds:
  - REG_W=5, DATA_W=32;
  - packed struct wb_entry_t {live, wa, wd, pc};
  - constant REG_ZERO=5'd0.
- One natural sub-module, wb_aux_fifo. It contains storage, pointers, count, live bits, the kill-by-address port and the two match ports.
- Arbitration, output register and trace live in the top module.

Test Plan:
- Reset with aux_valid=1 and pipe_we=1 held -> all grf_* outputs 0, pending_cnt=0, aux_ready=1 one cycle after reset deasserts.
- Pipe only: pipe_we=1, wa=8, wd=0x1234, pc=0x3000 -> the next cycle shows grf_we=1, grf_wa=8, grf_wd=0x1234, grf_pc=0x3000.
- Fill: push 4 aux writes (wa=1..4) while pipe_we=1 each cycle:
  - aux_ready=0 and pending_cnt=4;
  - rs_addr=3 gives rs_pending=1.
  - Then drop pipe_we: writes for wa=1,2,3,4 emit on 4 consecutive cycles and aux_ready returns high.
- WAW kill: queue aux wa=5 wd=0xAAAA, then pipe write wa=5 wd=0xBBBB:
  - grf shows 0xBBBB;
  - the head pops later with grf_we=0;
  - rs_pending for 5 is 0 right after the kill.
- Zero register: aux_valid with aux_wa=0 -> handshake completes, pending_cnt unchanged. pipe_we with wa=0 -> grf_we stays 0 and the FIFO head pops instead.
- Wrap: more than 8 push/pop pairs at full throughput -> data order is preserved and pending_cnt stays at or below DEPTH.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the GRF writeback arbiter and its aux FIFO.
package wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_aux_fifo.sv
// Aux writeback FIFO: circular storage with per-entry live bits, address kill
// and two address-match queries used as the pending scoreboard.
module wb_aux_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_en,
    input  logic [REG_W-1:0]  push_wa,
    input  logic [DATA_W-1:0] push_wd,
    input  logic [DATA_W-1:0] push_pc,
    input  logic              pop_en,
    input  logic              kill_en,
    input  logic [REG_W-1:0]  kill_wa,
    input  logic [REG_W-1:0]  q1_addr,
    input  logic [REG_W-1:0]  q2_addr,
    output wb_entry_t         head_entry,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    output logic              q1_match,
    output logic              q2_match,
    output logic [DEPTH-1:0]  kill_mask
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [REG_W-1:0]  wa_mem [DEPTH];
    logic [DATA_W-1:0] wd_mem [DEPTH];
    logic [DATA_W-1:0] pc_mem [DEPTH];

    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;

    logic [DEPTH-1:0] kill_hit;
    logic [DEPTH-1:0] q1_hit;
    logic [DEPTH-1:0] q2_hit;

    // Vacated slots always have live=0, so live alone marks a pending write.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign kill_hit[gi] = live_q[gi] && (wa_mem[gi] == kill_wa);
        assign q1_hit[gi]   = live_q[gi] && (wa_mem[gi] == q1_addr);
        assign q2_hit[gi]   = live_q[gi] && (wa_mem[gi] == q2_addr);
    end

    assign kill_mask = kill_en ? kill_hit : '0;
    assign q1_match  = (|q1_hit) && (q1_addr != REG_ZERO);
    assign q2_match  = (|q2_hit) && (q2_addr != REG_ZERO);

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign count      = count_q;
    assign head_entry = '{live: live_q[head_q], wa: wa_mem[head_q],
                          wd: wd_mem[head_q], pc: pc_mem[head_q]};

    // Kill first, then pop, then push: a same-cycle push is younger than the killer.
    always_comb begin
        live_d  = live_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
        if (kill_en) begin
            live_d = live_d & ~kill_hit;
        end
        if (pop_en) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end
        if (push_en) begin
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            wa_mem[tail_q] <= push_wa;
            wd_mem[tail_q] <= push_wd;
            pc_mem[tail_q] <= push_pc;
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-port producer: fixed-priority pipeline writeback merged with a
// buffered aux source. Optional trace output under macro WB_TRACE_EN.
module grf_wb_arbiter
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [REG_W-1:0]  pipe_wa,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic [DATA_W-1:0] pipe_pc,
    input  logic              aux_valid,
    input  logic [REG_W-1:0]  aux_wa,
    input  logic [DATA_W-1:0] aux_wd,
    input  logic [DATA_W-1:0] aux_pc,
    output logic              aux_ready,
    output logic              grf_we,
    output logic [REG_W-1:0]  grf_wa,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc,
    input  logic [REG_W-1:0]  rs_addr,
    input  logic [REG_W-1:0]  rt_addr,
    output logic              rs_pending,
    output logic              rt_pending,
    output logic [AW:0]       pending_cnt
);

    logic              pipe_valid;
    logic              aux_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    wb_entry_t         head_entry;
    logic [DEPTH-1:0]  kill_mask;

    logic              grf_we_q, grf_we_d;
    logic [REG_W-1:0]  grf_wa_q, grf_wa_d;
    logic [DATA_W-1:0] grf_wd_q, grf_wd_d;
    logic [DATA_W-1:0] grf_pc_q, grf_pc_d;

    assign pipe_valid = pipe_we && (pipe_wa != REG_ZERO);
    // Ready comes from state only; a full FIFO refuses even while popping.
    assign aux_ready  = !fifo_full;
    assign aux_push   = aux_valid && !fifo_full && (aux_wa != REG_ZERO);
    assign fifo_pop   = !pipe_valid && !fifo_empty;

    wb_aux_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_en    (aux_push),
        .push_wa    (aux_wa),
        .push_wd    (aux_wd),
        .push_pc    (aux_pc),
        .pop_en     (fifo_pop),
        .kill_en    (pipe_valid),
        .kill_wa    (pipe_wa),
        .q1_addr    (rs_addr),
        .q2_addr    (rt_addr),
        .head_entry (head_entry),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (pending_cnt),
        .q1_match   (rs_pending),
        .q2_match   (rt_pending),
        .kill_mask  (kill_mask)
    );

    // Stale heads are popped without a write; address/data hold when idle.
    always_comb begin
        grf_we_d = 1'b0;
        grf_wa_d = grf_wa_q;
        grf_wd_d = grf_wd_q;
        grf_pc_d = grf_pc_q;
        if (pipe_valid) begin
            grf_we_d = 1'b1;
            grf_wa_d = pipe_wa;
            grf_wd_d = pipe_wd;
            grf_pc_d = pipe_pc;
        end else if (!fifo_empty && head_entry.live) begin
            grf_we_d = 1'b1;
            grf_wa_d = head_entry.wa;
            grf_wd_d = head_entry.wd;
            grf_pc_d = head_entry.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we_q <= 1'b0;
            grf_wa_q <= '0;
            grf_wd_q <= '0;
            grf_pc_q <= '0;
        end else begin
            grf_we_q <= grf_we_d;
            grf_wa_q <= grf_wa_d;
            grf_wd_q <= grf_wd_d;
            grf_pc_q <= grf_pc_d;
        end
    end

    assign grf_we = grf_we_q;
    assign grf_wa = grf_wa_q;
    assign grf_wd = grf_wd_q;
    assign grf_pc = grf_pc_q;

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (grf_we_q) begin
                $display("@%h: $%0d <= %h", grf_pc_q, grf_wa_q, grf_wd_q);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_mask[i]) begin
                    $display("KILL $%0d", pipe_wa);
                end
            end
        end
    end
`else
    logic unused_kill_mask;
    assign unused_kill_mask = |kill_mask;
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Scoreboard bench for grf_wb_arbiter: expected GRF writes are queued per cycle
// as stimulus is driven and compared two time units after each clock edge.
module tb_grf_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } out_t;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        aux_valid;
    logic [4:0]  aux_wa;
    logic [31:0] aux_wd;
    logic [31:0] aux_pc;
    logic        aux_ready;
    logic        grf_we;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_pending;
    logic        rt_pending;
    logic [AW:0] pending_cnt;

    wb_entry_t model_q[$];
    out_t      exp_q[$];
    out_t      last_exp;
    out_t      mon_e;
    int        n_checks;
    int        n_fail;

    grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we     (pipe_we),
        .pipe_wa     (pipe_wa),
        .pipe_wd     (pipe_wd),
        .pipe_pc     (pipe_pc),
        .aux_valid   (aux_valid),
        .aux_wa      (aux_wa),
        .aux_wd      (aux_wd),
        .aux_pc      (aux_pc),
        .aux_ready   (aux_ready),
        .grf_we      (grf_we),
        .grf_wa      (grf_wa),
        .grf_wd      (grf_wd),
        .grf_pc      (grf_pc),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_pending  (rs_pending),
        .rt_pending  (rt_pending),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: one expectation per driven cycle.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (grf_we !== mon_e.we || grf_wa !== mon_e.wa ||
                grf_wd !== mon_e.wd || grf_pc !== mon_e.pc) begin
                n_fail++;
                $display("FAIL grf_out: got we=%0b wa=%0d wd=%h pc=%h, expected we=%0b wa=%0d wd=%h pc=%h",
                         grf_we, grf_wa, grf_wd, grf_pc, mon_e.we, mon_e.wa, mon_e.wd, mon_e.pc);
            end
        end
    end

    // Drive one cycle of stimulus (at a negedge) and queue the expected GRF output.
    task automatic cycle(input logic pv, input logic [4:0] pwa, input logic [31:0] pwd,
                         input logic [31:0] ppc, input logic av, input logic [4:0] awa,
                         input logic [31:0] awd, input logic [31:0] apc);
        out_t      e;
        wb_entry_t h;
        bit        ready;
        ready = (model_q.size() < DEPTH);
        e     = last_exp;
        e.we  = 1'b0;
        if (pv && pwa != 5'd0) begin
            e = '{we: 1'b1, wa: pwa, wd: pwd, pc: ppc};
            foreach (model_q[i]) begin
                if (model_q[i].wa == pwa) model_q[i].live = 1'b0;
            end
        end else if (model_q.size() > 0) begin
            h = model_q.pop_front();
            if (h.live) e = '{we: 1'b1, wa: h.wa, wd: h.wd, pc: h.pc};
        end
        if (av && ready && awa != 5'd0) begin
            model_q.push_back('{live: 1'b1, wa: awa, wd: awd, pc: apc});
        end
        last_exp = e;
        exp_q.push_back(e);
        pipe_we   = pv;
        pipe_wa   = pwa;
        pipe_wd   = pwd;
        pipe_pc   = ppc;
        aux_valid = av;
        aux_wa    = awa;
        aux_wd    = awd;
        aux_pc    = apc;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        pipe_we   = 1'b1;
        pipe_wa   = 5'd9;
        pipe_wd   = 32'h5555;
        pipe_pc   = 32'h100;
        aux_valid = 1'b1;
        aux_wa    = 5'd7;
        aux_wd    = 32'h6666;
        aux_pc    = 32'h104;
        repeat (3) @(negedge clk);
        n_checks++;
        if (grf_we !== 1'b0 || grf_wa !== 5'd0 || grf_wd !== 32'd0 || grf_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_grf: got we=%0b wa=%0d wd=%h pc=%h, expected all zero",
                     grf_we, grf_wa, grf_wd, grf_pc);
        end
        n_checks++;
        if (pending_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d, expected 0", pending_cnt);
        end
        reset     = 1'b0;
        pipe_we   = 1'b0;
        aux_valid = 1'b0;
        last_exp  = '0;
        @(negedge clk);
        n_checks++;
        if (aux_ready !== 1'b1 || pending_cnt !== 3'd0 || grf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got ready=%0b cnt=%0d we=%0b, expected ready=1 cnt=0 we=0",
                     aux_ready, pending_cnt, grf_we);
        end
    endtask

    task automatic test_pipe_only();
        cycle(1'b1, 5'd8, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++;
        if (grf_we !== 1'b1 || grf_wa !== 5'd8 || grf_wd !== 32'h1234 || grf_pc !== 32'h3000) begin
            n_fail++;
            $display("FAIL pipe_only: got we=%0b wa=%0d wd=%h pc=%h, expected 1/8/1234/3000",
                     grf_we, grf_wa, grf_wd, grf_pc);
        end
        idle();
        n_checks++;
        if (grf_we !== 1'b0 || grf_wd !== 32'h1234) begin
            n_fail++;
            $display("FAIL pipe_hold: got we=%0b wd=%h, expected we=0 wd=1234", grf_we, grf_wd);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'(10 + i), 32'h5000 + 32'(i), 32'h3100 + 32'(4 * i),
                  1'b1, 5'(1 + i), 32'hA000 + 32'(i), 32'h2000 + 32'(4 * i));
        end
        n_checks++;
        if (aux_ready !== 1'b0 || pending_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_full: got ready=%0b cnt=%0d, expected ready=0 cnt=4",
                     aux_ready, pending_cnt);
        end
        rs_addr = 5'd3;
        rt_addr = 5'd9;
        #1;
        n_checks++;
        if (rs_pending !== 1'b1 || rt_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_pending: got rs=%0b rt=%0b, expected rs=1 rt=0", rs_pending, rt_pending);
        end
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        // Offer while full and popping: must be refused.
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd6, 32'hDEAD, 32'h2100);
        n_checks++;
        if (pending_cnt !== 3'd3 || aux_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_refuse: got cnt=%0d ready=%0b, expected cnt=3 ready=1",
                     pending_cnt, aux_ready);
        end
        repeat (3) idle();
        n_checks++;
        if (pending_cnt !== 3'd0 || aux_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_drain: got cnt=%0d ready=%0b, expected cnt=0 ready=1",
                     pending_cnt, aux_ready);
        end
    endtask

    task automatic test_waw();
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'hAAAA, 32'h4000);
        cycle(1'b1, 5'd5, 32'hBBBB, 32'h4100, 1'b0, 5'd0, 32'd0, 32'd0);
        rs_addr = 5'd5;
        #1;
        n_checks++;
        if (rs_pending !== 1'b0 || pending_cnt !== 3'd1 || grf_wd !== 32'hBBBB) begin
            n_fail++;
            $display("FAIL waw_kill: got rs=%0b cnt=%0d wd=%h, expected rs=0 cnt=1 wd=bbbb",
                     rs_pending, pending_cnt, grf_wd);
        end
        idle();
        n_checks++;
        if (pending_cnt !== 3'd0 || grf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_stale_pop: got cnt=%0d we=%0b, expected cnt=0 we=0", pending_cnt, grf_we);
        end
        // Same-cycle younger push to the killed register survives.
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'hAAAA, 32'h4200);
        cycle(1'b1, 5'd5, 32'hBBBB, 32'h4300, 1'b1, 5'd5, 32'hCCCC, 32'h4400);
        #1;
        n_checks++;
        if (rs_pending !== 1'b1 || pending_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL waw_younger: got rs=%0b cnt=%0d, expected rs=1 cnt=2", rs_pending, pending_cnt);
        end
        rs_addr = 5'd0;
        idle();
        idle();
        n_checks++;
        if (grf_we !== 1'b1 || grf_wd !== 32'hCCCC || pending_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL waw_survivor: got we=%0b wd=%h cnt=%0d, expected we=1 wd=cccc cnt=0",
                     grf_we, grf_wd, pending_cnt);
        end
    endtask

    task automatic test_zero_reg();
        n_checks++;
        if (aux_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %0b, expected 1", aux_ready);
        end
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'h7777, 32'h5000);
        n_checks++;
        if (pending_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL zero_aux_drop: got cnt=%0d, expected 0", pending_cnt);
        end
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd7, 32'h7070, 32'h5004);
        cycle(1'b1, 5'd0, 32'h9999, 32'h5008, 1'b0, 5'd0, 32'd0, 32'd0);
        n_checks++;
        if (grf_we !== 1'b1 || grf_wa !== 5'd7 || grf_wd !== 32'h7070 || pending_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL zero_pipe_pop: got we=%0b wa=%0d wd=%h cnt=%0d, expected 1/7/7070/0",
                     grf_we, grf_wa, grf_wd, pending_cnt);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd1, 32'hC000, 32'h6000);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'((i % 3) + 1), 32'hC001 + 32'(i), 32'h6004 + 32'(4 * i));
            n_checks++;
            if (pending_cnt !== 3'd1) begin
                n_fail++;
                $display("FAIL wrap_cnt[%0d]: got %0d, expected 1", i, pending_cnt);
            end
        end
        idle();
    endtask

    task automatic test_random();
        logic pv, av;
        for (int i = 0; i < 80; i++) begin
            pv = ($urandom_range(0, 2) == 0);
            av = ($urandom_range(0, 3) != 0);
            cycle(pv, 5'($urandom_range(0, 6)), $urandom(), $urandom(),
                  av, 5'($urandom_range(0, 6)), $urandom(), $urandom());
            n_checks++;
            if (pending_cnt !== 3'(model_q.size()) || aux_ready !== (model_q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got cnt=%0d ready=%0b, expected cnt=%0d ready=%0b",
                         i, pending_cnt, aux_ready, model_q.size(), (model_q.size() < DEPTH));
            end
        end
        for (int i = 0; i < 2 * DEPTH && model_q.size() > 0; i++) idle();
        idle();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        last_exp  = '0;
        reset     = 1'b1;
        pipe_we   = 1'b0;
        pipe_wa   = '0;
        pipe_wd   = '0;
        pipe_pc   = '0;
        aux_valid = 1'b0;
        aux_wa    = '0;
        aux_wd    = '0;
        aux_pc    = '0;
        rs_addr   = '0;
        rt_addr   = '0;
        @(negedge clk);
        test_reset();
        test_pipe_only();
        test_fill();
        test_waw();
        test_zero_reg();
        test_wrap();
        test_random();
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
